// File: rtl/fifo_rd_stream_stage.sv
// fifo_rd_stream_stage: read-side FIFO consumer feeding a 2-entry valid/ready output buffer with burst framing.
// Ports:
//   r_clk, rrst      read-domain clock and synchronous active-high reset
//   flush            synchronous clear of buffer and beat counter (FIFO not popped)
//   r_empty, rdata   FIFO empty flag and combinational head word
//   r_en             FIFO pop strobe
//   m_data, m_valid, m_last, m_ready   downstream stream
//   beat_cnt         beats accepted in the current burst
module fifo_rd_stream_stage #(
    parameter int MEMORY_WIDTH = 8,
    parameter int BURST_LEN    = 16,
    parameter int CNT_WIDTH    = 5
) (
    input  logic                    r_clk,
    input  logic                    rrst,
    input  logic                    flush,
    input  logic                    r_empty,
    input  logic [MEMORY_WIDTH-1:0] rdata,
    output logic                    r_en,
    output logic [MEMORY_WIDTH-1:0] m_data,
    output logic                    m_valid,
    output logic                    m_last,
    input  logic                    m_ready,
    output logic [CNT_WIDTH-1:0]    beat_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);
    state_t                  state_q, state_d;
    logic [MEMORY_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [CNT_WIDTH-1:0]    beat_q, beat_d;
    logic                    push, pop;
    always_comb begin
        // r_en looks only at registered occupancy so it never combinationally depends on m_ready
        r_en     = !rrst && !flush && !r_empty && state_q != TWO;
        m_valid  = !rrst && state_q != EMPTY;
        m_data   = rrst ? '0 : e0_q;
        m_last   = m_valid && beat_q == LAST_BEAT;
        beat_cnt = rrst ? '0 : beat_q;
        push     = r_en;
        pop      = m_valid && m_ready;
        state_d  = state_q;
        e0_d     = e0_q;
        e1_d     = e1_q;
        beat_d   = pop ? (beat_q == LAST_BEAT ? '0 : beat_q + CNT_WIDTH'(1)) : beat_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    e0_d    = rdata;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d = TWO;
                    e1_d    = rdata;
                end else if (push) begin
                    e0_d = rdata;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    e0_d    = e1_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            e0_d    = '0;
            e1_d    = '0;
            beat_d  = '0;
        end
    end
    always_ff @(posedge r_clk) begin
        if (rrst) begin
            state_q <= EMPTY;
            e0_q    <= '0;
            e1_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            beat_q  <= beat_d;
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream_stage.sv
// tb_fifo_rd_stream_stage: scoreboard bench for fifo_rd_stream_stage with a queue-modelled FIFO source.
module tb_fifo_rd_stream_stage;
    localparam int BL = 16;
    logic       clk = 1'b0, rrst = 1'b1, flush = 1'b0, r_empty = 1'b1, m_ready = 1'b1;
    logic [7:0] rdata = '0;
    logic       r_en, m_valid, m_last;
    logic [7:0] m_data;
    logic [4:0] beat_cnt;
    int         checks = 0, errors = 0, mbeat = 0, ren_cnt = 0, pops = 0;
    logic [7:0] src[$], exp_q[$];
    logic [7:0] last_word = '0, first_word = '0;

    fifo_rd_stream_stage #(.MEMORY_WIDTH(8), .BURST_LEN(BL), .CNT_WIDTH(5)) dut (
        .r_clk(clk), .rrst(rrst), .flush(flush), .r_empty(r_empty), .rdata(rdata),
        .r_en(r_en), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive();
        r_empty = src.size() == 0;
        rdata   = src.size() != 0 ? src[0] : 8'hxx;
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) src.push_back(base + 8'(i));
        drive();
    endtask

    task automatic cycle();
        @(negedge clk);
        if (rrst) begin
            chk("rst_valid", m_valid, 0);
            chk("rst_data", m_data, 0);
            chk("rst_last", m_last, 0);
            chk("rst_beat", beat_cnt, 0);
        end else begin
            chk("m_valid", m_valid, exp_q.size() != 0);
            if (m_valid && exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
            chk("beat_cnt", beat_cnt, mbeat);
            chk("m_last", m_last, m_valid && mbeat == BL - 1);
        end
        chk("r_en", r_en, !rrst && !flush && src.size() != 0 && exp_q.size() < 2);
        if (r_en) ren_cnt++;
        if (rrst || flush) begin
            exp_q.delete();
            mbeat = 0;
        end else begin
            if (m_valid && m_ready && exp_q.size() != 0) begin
                if (pops == 0) first_word = m_data;
                if (m_last) last_word = m_data;
                pops++;
                void'(exp_q.pop_front());
                mbeat = (mbeat == BL - 1) ? 0 : mbeat + 1;
            end
            if (r_en && src.size() != 0) exp_q.push_back(src.pop_front());
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while ((src.size() != 0 || exp_q.size() != 0) && k < bound) begin
            cycle();
            k++;
        end
        chk("drain_timeout", src.size() + exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        src.push_back(8'hAA);
        drive();
        run(3);
        rrst = 1'b0;
        src.delete();
        fill(8'h01, 16);
        ren_cnt = 0;
        run(16);
        chk("t2_ren16", ren_cnt, 16);
        drain(10);
        chk("t2_last", last_word, 8'h10);
        chk("t2_beat0", beat_cnt, 0);

        m_ready = 1'b0;
        ren_cnt = 0;
        fill(8'h01, 5);
        run(6);
        chk("t3_ren2", ren_cnt, 2);
        chk("t3_hold", m_data, 8'h01);
        m_ready = 1'b1;
        pops = 0;
        run(5);
        chk("t3_nogap", pops, 5);
        chk("t3_beat5", beat_cnt, 5);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        chk("flush_beat0", beat_cnt, 0);

        fill(8'h21, 3);
        run(6);
        chk("t4_valid0", m_valid, 0);
        chk("t4_beat3", beat_cnt, 3);
        run(2);
        chk("t4_beat3_held", beat_cnt, 3);
        fill(8'h31, 13);
        drain(30);
        chk("t4_last", last_word, 8'h3D);
        chk("t4_beat0", beat_cnt, 0);

        m_ready = 1'b0;
        fill(8'h07, 4);
        run(3);
        chk("t5_head", m_data, 8'h07);
        flush = 1'b1;
        #1;
        chk("t5_ren0", r_en, 0);
        cycle();
        flush = 1'b0;
        #1;
        chk("t5_valid0", m_valid, 0);
        chk("t5_beat0", beat_cnt, 0);
        m_ready = 1'b1;
        pops = 0;
        drain(20);
        chk("t5_first", first_word, 8'h09);

        begin
            int k = 0;
            fill(8'h41, 16);
            while (beat_cnt != 9 && k < 40) begin
                cycle();
                k++;
            end
        end
        chk("t6_reach9", beat_cnt, 9);
        m_ready = 1'b0;
        run(2);
        chk("t6_beat9", beat_cnt, 9);
        chk("t6_full", r_en, 0);
        rrst = 1'b1;
        cycle();
        rrst = 1'b0;
        #1;
        chk("t6_valid0", m_valid, 0);
        chk("t6_beat0", beat_cnt, 0);
        m_ready = 1'b1;
        drain(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
